// File: rtl/header_ram_fifo_pkg.sv
// Shared sizing helpers for the header RAM FIFO controller and its output stage.
package header_ram_fifo_pkg;

    localparam int OCNT_W = 2;  // output-stage occupancy 0..2

    function automatic int fifo_depth(input int ram_adrb);
        return 1 << ram_adrb;
    endfunction

    // One extra MSB lets equal addresses mean either empty or full.
    function automatic int ptr_width(input int ram_adrb);
        return ram_adrb + 1;
    endfunction

endpackage

// File: rtl/header_ram_fifo_if.sv
// Bundle of writer, consumer and RAM-port signals around the header RAM FIFO.
interface header_ram_fifo_if
    import header_ram_fifo_pkg::*;
#(
    parameter int RAM_WIDTH = 9,
    parameter int RAM_ADRB  = 11
);
    logic                           flush;
    logic                           wr_en;
    logic [RAM_WIDTH-1:0]           wr_data;
    logic                           wr_full;
    logic                           wr_overflow;
    logic                           rd_valid;
    logic [RAM_WIDTH-1:0]           rd_data;
    logic                           rd_ready;
    logic [ptr_width(RAM_ADRB)-1:0] wr_count;
    logic                           empty;
    logic                           ram_wea;
    logic [RAM_ADRB-1:0]            ram_adra;
    logic [RAM_WIDTH-1:0]           ram_dataa;
    logic                           ram_enb;
    logic [RAM_ADRB-1:0]            ram_adrb;
    logic [RAM_WIDTH-1:0]           ram_datab;

    // The FIFO controller side.
    modport slave (
        input  flush, wr_en, wr_data, rd_ready, ram_datab,
        output wr_full, wr_overflow, rd_valid, rd_data, wr_count, empty,
               ram_wea, ram_adra, ram_dataa, ram_enb, ram_adrb
    );

    // The surrounding system: header builder, readout sequencer and RAM.
    modport master (
        output flush, wr_en, wr_data, rd_ready, ram_datab,
        input  wr_full, wr_overflow, rd_valid, rd_data, wr_count, empty,
               ram_wea, ram_adra, ram_dataa, ram_enb, ram_adrb
    );
endinterface

// File: rtl/header_ram_fifo_ostage.sv
// Two-entry head/skid output stage that absorbs the 1-cycle RAM read latency.
module header_ram_fifo_ostage
    import header_ram_fifo_pkg::*;
#(
    parameter int RAM_WIDTH = 9
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 load,
    input  logic [RAM_WIDTH-1:0] load_data,
    input  logic                 pop,
    output logic [OCNT_W-1:0]    out_cnt,
    output logic                 rd_valid,
    output logic [RAM_WIDTH-1:0] rd_data
);
    logic [RAM_WIDTH-1:0] head_q, head_d, skid_q, skid_d;
    logic [OCNT_W-1:0]    cnt_q, cnt_d;

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        cnt_d  = cnt_q;
        if (clear) begin
            head_d = '0;
            skid_d = '0;
            cnt_d  = '0;
        end else begin
            if (pop) begin
                if (cnt_q == 2'd2) head_d = skid_q;
                cnt_d = cnt_q - 2'd1;
            end
            // The fetch rule guarantees at most one entry remains when a load lands.
            if (load) begin
                if (cnt_d == 2'd0) head_d = load_data;
                else               skid_d = load_data;
                cnt_d = cnt_d + 2'd1;
            end
        end
    end

    // NOTE: sequential state uses nonblocking assignments only; these are plain
    // flops (not RAM), so they take a reset value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_cnt  = cnt_q;
    assign rd_valid = (cnt_q != '0);
    assign rd_data  = head_q;
endmodule

// File: rtl/header_ram_fifo.sv
// Circular-buffer controller turning a dual-port header RAM into a FWFT valid/ready FIFO.
module header_ram_fifo
    import header_ram_fifo_pkg::*;
#(
    parameter int RAM_WIDTH = 9,
    parameter int RAM_ADRB  = 11
) (
    input  logic              clock,
    input  logic              reset_n,
    header_ram_fifo_if.slave  bus
);
    localparam int DEPTH = fifo_depth(RAM_ADRB);
    localparam int PW    = ptr_width(RAM_ADRB);

    typedef logic [PW-1:0] ptr_t;

    ptr_t                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    ptr_t                 ram_words, wr_count;
    logic [RAM_ADRB-1:0]  adrb_q, adrb_d;
    logic                 inflight_q, inflight_d;
    logic                 ovf_q, ovf_d;
    logic [OCNT_W-1:0]    out_cnt;
    logic                 rd_valid;
    logic [RAM_WIDTH-1:0] rd_data;
    logic [2:0]           occ;
    logic                 full, accept, pop, fetch;

    assign ram_words = wr_ptr_q - rd_ptr_q;
    assign wr_count  = ram_words + ptr_t'(inflight_q) + ptr_t'(out_cnt);
    assign full      = (wr_count == ptr_t'(DEPTH));
    assign pop       = rd_valid & bus.rd_ready;

    // Full is judged on registered state, so a pop in the same cycle cannot free a slot.
    assign accept = reset_n & bus.wr_en & ~full & ~bus.flush;

    assign occ   = {1'b0, out_cnt} + {2'b0, inflight_q};
    assign fetch = ~bus.flush & (ram_words != '0) & (occ < (3'd2 + {2'b0, pop}));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        adrb_d     = adrb_q;
        inflight_d = 1'b0;
        ovf_d      = ovf_q;
        if (bus.flush) begin
            // Port B address is left alone; everything else returns to empty.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (accept) wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (fetch) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
                adrb_d   = rd_ptr_q[RAM_ADRB-1:0];
            end
            inflight_d = fetch;
            if (bus.wr_en && full) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            adrb_q     <= '0;
            inflight_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            adrb_q     <= adrb_d;
            inflight_q <= inflight_d;
            ovf_q      <= ovf_d;
        end
    end

    // A read issued just before a flush returns data that must not be captured.
    header_ram_fifo_ostage #(.RAM_WIDTH(RAM_WIDTH)) u_ostage (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (bus.flush),
        .load      (inflight_q & ~bus.flush),
        .load_data (bus.ram_datab),
        .pop       (pop),
        .out_cnt   (out_cnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
    );

    assign bus.wr_full     = full;
    assign bus.wr_overflow = ovf_q;
    assign bus.rd_valid    = rd_valid;
    assign bus.rd_data     = rd_data;
    assign bus.wr_count    = wr_count;
    assign bus.empty       = (wr_count == '0);
    assign bus.ram_wea     = accept;
    assign bus.ram_adra    = wr_ptr_q[RAM_ADRB-1:0];
    assign bus.ram_dataa   = bus.wr_data;
    assign bus.ram_enb     = fetch;
    assign bus.ram_adrb    = fetch ? rd_ptr_q[RAM_ADRB-1:0] : adrb_q;
endmodule

// File: tb/tb_header_ram_fifo.sv
// Scoreboard bench for header_ram_fifo with a behavioural 1-cycle-read dual-port RAM.
module tb_header_ram_fifo;
    import header_ram_fifo_pkg::*;

    localparam int W     = 9;
    localparam int A     = 11;
    localparam int DEPTH = fifo_depth(A);

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    header_ram_fifo_if #(.RAM_WIDTH(W), .RAM_ADRB(A)) bus ();

    header_ram_fifo #(.RAM_WIDTH(W), .RAM_ADRB(A)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Dual-port RAM: port A write, port B registered read.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (bus.ram_wea) mem[bus.ram_adra] <= bus.ram_dataa;
        if (bus.ram_enb) bus.ram_datab <= mem[bus.ram_adrb];
    end

    int coll_cnt = 0;
    always @(posedge clock) begin
        if (reset_n && bus.ram_wea && bus.ram_enb && (bus.ram_adra == bus.ram_adrb))
            coll_cnt++;
    end

    int           n_checks  = 0;
    int           n_errors  = 0;
    logic [W-1:0] exp_q[$];
    int           model_cnt = 0;
    logic         model_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_rd_valid"},    32'(bus.rd_valid),    0);
        check({pfx, "_rd_data"},     32'(bus.rd_data),     0);
        check({pfx, "_wr_count"},    32'(bus.wr_count),    0);
        check({pfx, "_empty"},       32'(bus.empty),       1);
        check({pfx, "_wr_full"},     32'(bus.wr_full),     0);
        check({pfx, "_wr_overflow"}, 32'(bus.wr_overflow), 0);
        check({pfx, "_ram_wea"},     32'(bus.ram_wea),     0);
        check({pfx, "_ram_enb"},     32'(bus.ram_enb),     0);
        check({pfx, "_ram_adra"},    32'(bus.ram_adra),    0);
        check({pfx, "_ram_adrb"},    32'(bus.ram_adrb),    0);
    endtask

    // One clock: drive at the falling edge, settle, predict, clock, sample at the next fall.
    task automatic step(input logic wr, input logic [W-1:0] d, input logic rdy, input logic fl);
        logic acc;
        bus.wr_en    = wr;
        bus.wr_data  = d;
        bus.rd_ready = rdy;
        bus.flush    = fl;
        #1;
        acc = wr && !fl && (model_cnt < DEPTH);
        check("ram_wea", 32'(bus.ram_wea), 32'(acc));
        if (fl) begin
            exp_q.delete();
            model_cnt = 0;
            model_ovf = 1'b0;
        end else begin
            if (rdy && bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("pop_with_model_empty", 32'(bus.rd_valid), 0);
                end else begin
                    check("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
                    model_cnt--;
                end
            end
            if (wr && !acc) model_ovf = 1'b1;
            if (acc) begin
                exp_q.push_back(d);
                model_cnt++;
            end
        end
        @(posedge clock);
        @(negedge clock);
        check("wr_count",    32'(bus.wr_count),    32'(model_cnt));
        check("empty",       32'(bus.empty),       32'(model_cnt == 0));
        check("wr_full",     32'(bus.wr_full),     32'(model_cnt == DEPTH));
        check("wr_overflow", 32'(bus.wr_overflow), 32'(model_ovf));
        if (model_cnt == 0) check("rd_valid_when_empty", 32'(bus.rd_valid), 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int written;
        int n;
        int bubbles;
        logic seen;
        logic wr;
        logic rdy;
        logic [W-1:0] d;

        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        bus.flush    = 1'b0;

        // Reset state
        #12;
        check_reset_values("rst");
        @(negedge clock);
        reset_n = 1'b1;

        // Single word latency: visible after the write, fetch and capture edges
        step(1'b1, 9'h1A5, 1'b0, 1'b0);
        check("lat_valid_e1", 32'(bus.rd_valid), 0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("lat_valid_e2", 32'(bus.rd_valid), 0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("lat_valid_e3", 32'(bus.rd_valid), 1);
        check("lat_data",     32'(bus.rd_data),  32'h1A5);
        drain(10);

        // Streaming 0..99 with rd_ready high: no bubbles once data starts
        bubbles = 0;
        seen    = 1'b0;
        n       = 0;
        while ((n < 100 || exp_q.size() != 0) && n < 120) begin
            if (bus.rd_valid) seen = 1'b1;
            else if (seen && exp_q.size() != 0) bubbles++;
            if (n < 100) step(1'b1, W'(n), 1'b1, 1'b0);
            else         step(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        check("stream_bubbles", 32'(bubbles), 0);
        check("stream_drained", 32'(exp_q.size()), 0);

        // Fill to DEPTH, overflow, then a write+pop while full
        for (int i = 0; i < DEPTH; i++) step(1'b1, W'(i * 37 + 5), 1'b0, 1'b0);
        check("fill_full", 32'(bus.wr_full), 1);
        step(1'b1, 9'h0AA, 1'b0, 1'b0);
        check("ovf_set", 32'(bus.wr_overflow), 1);
        step(1'b1, 9'h0BB, 1'b1, 1'b0);
        check("full_clears_after_pop", 32'(bus.wr_full), 0);
        drain(DEPTH + 20);
        check("ovf_sticky", 32'(bus.wr_overflow), 1);

        // Flush with a read in flight and a valid head word
        step(1'b1, 9'h111, 1'b0, 1'b0);
        step(1'b1, 9'h122, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("pre_flush_valid", 32'(bus.rd_valid), 1);
        step(1'b1, 9'h133, 1'b0, 1'b1);
        check("flush_rd_valid", 32'(bus.rd_valid), 0);
        check("flush_rd_data",  32'(bus.rd_data),  0);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic across pointer wrap
        written = 0;
        n       = 0;
        while (written < 5000 && n < 20000) begin
            wr  = ($urandom_range(0, 3) != 0);
            rdy = 1'($urandom_range(0, 1));
            d   = W'($urandom);
            if (wr && model_cnt < DEPTH) written++;
            step(wr, d, rdy, 1'b0);
            n++;
        end
        check("wrap_written", 32'(written), 5000);
        drain(DEPTH + 50);
        check("no_port_collision", 32'(coll_cnt), 0);

        // Asynchronous reset between clock edges, write still requested
        step(1'b1, 9'h001, 1'b1, 1'b0);
        step(1'b1, 9'h002, 1'b1, 1'b0);
        step(1'b1, 9'h003, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        exp_q.delete();
        model_cnt    = 0;
        model_ovf    = 1'b0;
        bus.wr_en    = 1'b0;
        bus.rd_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 9'h0C3, 1'b1, 1'b0);
        drain(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/header_ram_fifo.md
Name: header_ram_fifo

Overview:
- Circular-buffer controller that turns the dual-port header RAM (port A write-only, port B read-only, 1-cycle registered read) into a FIFO with a first-word-fall-through valid/ready output.
- Sits between the header builder (upstream writer) and the readout sequencer (downstream consumer).
- Owns both RAM address pointers, all full/empty/count bookkeeping, and a 2-entry output stage. This hides RAM read latency and sustains 1 word/clock.

Parameters:
RAM_WIDTH, 9, data width in bits; must equal the attached RAM's width.
RAM_ADRB, 11, address bits; FIFO depth DEPTH = 2**RAM_ADRB words.

Ports:
clock  in  1  single system clock; RAM is clocked by the same clock.
reset_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous clear of pointers, count and output stage.
wr_en  in  1  write request from header builder.
wr_data  in  RAM_WIDTH  write data.
wr_full  out  1  buffer full; writes ignored while high.
wr_overflow  out  1  sticky: wr_en seen while full; cleared by reset_n or flush.
rd_valid  out  1  rd_data holds a valid word.
rd_data  out  RAM_WIDTH  head-of-FIFO word.
rd_ready  in  1  consumer accepts word when rd_valid&rd_ready.
wr_count  out  RAM_ADRB+1  words stored, including the output stage.
empty  out  1  wr_count==0.
ram_wea  out  1  to RAM port A write enable.
ram_adra  out  RAM_ADRB  to RAM port A address.
ram_dataa  out  RAM_WIDTH  to RAM port A data.
ram_enb  out  1  to RAM port B enable.
ram_adrb  out  RAM_ADRB  to RAM port B address.
ram_datab  in  RAM_WIDTH  from RAM port B; valid the cycle after ram_enb.

Behaviour:
- Reset (async, reset_n=0) values:
  - Pointers 0; wr_count 0; wr_full 0; wr_overflow 0; empty 1; rd_valid 0; rd_data 0.
  - ram_wea 0; ram_enb 0; ram_adra 0; ram_adrb 0.
- Write path (combinational to RAM):
  - ram_wea = wr_en & ~wr_full; ram_adra = wr_ptr[RAM_ADRB-1:0]; ram_dataa = wr_data.
  - wr_ptr increments on an accepted write. The pointer is RAM_ADRB+1 bits and wraps naturally at DEPTH.
- RAM occupancy: ram_words = wr_ptr - rd_ptr, computed modulo 2^(RAM_ADRB+1).
- Fetch rule:
  - Condition: ram_words>0 and (out_cnt + inflight - pop) < 2.
    - out_cnt: entries in the output stage, 0..2.
    - inflight: a read issued the previous cycle, 0/1.
    - pop: rd_valid & rd_ready.
  - When the condition holds: ram_enb=1, ram_adrb=rd_ptr[RAM_ADRB-1:0], rd_ptr increments.
  - Otherwise ram_enb=0 and ram_adrb holds its last value.
- Capture: the cycle after ram_enb=1, ram_datab is loaded into the output stage. Use the head register if it is empty or being popped, else the skid register.
- Output stage:
  - rd_data is driven from the head register; rd_valid = out_cnt>0.
  - On pop, skid moves to head if occupied.
  - rd_data holds its value while rd_valid & ~rd_ready.
- Latency: a write into an empty FIFO gives rd_valid=1 three clocks after the wr_en edge (write, fetch, capture).
- Throughput: with rd_ready held high, one word per clock continuously.
- Counts and flags:
  - wr_count = ram_words + inflight + out_cnt. It changes +1 on an accepted write, -1 on pop, and is unchanged when both occur.
  - wr_full = (wr_count == DEPTH). This is conservative, so RAM words are never overwritten.
- Collisions: port A and port B addresses are equal only when ram_words is 0 (no fetch) or DEPTH (no write). The controller therefore never reads the address being written in the same cycle.
- Simultaneous write and pop while full: the write is rejected (full is evaluated before pop) and wr_overflow is set. wr_full clears the next cycle.
- Flush:
  - Takes priority over all activity in the same cycle.
  - Next cycle: state equals post-reset, except ram_adrb, which holds its value.
  - An inflight read completing after flush is discarded.
  - A write in the flush cycle is dropped and does not set wr_overflow.
- Pointer wrap: the address bits roll DEPTH-1 -> 0 seamlessly; the MSB distinguishes full from empty.

Decomposition:
- Shared package: FIFO depth function DEPTH(RAM_ADRB) and the pointer-width constant RAM_ADRB+1.
- One natural sub-module: header_ram_fifo_ostage, the 2-entry valid/ready skid output stage. Its ports are load, load_data, pop, out_cnt, rd_valid and rd_data.
- The ramblock is instantiated by the parent, not inside this block.

Test Plan:
- Reset then single write 0x1A5 with rd_ready=0 -> rd_valid=1 and rd_data=0x1A5 three cycles later; wr_count=1; empty=0.
- Stream writes 0..99 with rd_ready=1 -> rd_data 0..99 in order, no bubbles after the first word, wr_count settles to 0.
- Fill to DEPTH=2048 with rd_ready=0 -> wr_full=1 at count 2048; an extra write sets wr_overflow=1 and data is uncorrupted on drain.
- Wrap: write/read 5000 words with random rd_ready -> in-order output across pointer wrap; never ram_wea&ram_enb with ram_adra==ram_adrb.
- Flush with an inflight read and rd_valid=1 -> next cycle rd_valid=0, wr_count=0, empty=1; the stale inflight word never appears.
- Assert reset_n low mid-stream (async, between edges) -> all outputs take reset values immediately; after release, the first new write reads back correctly.
